// File: rtl/pwm_sar_adc_ctrl.sv
// Successive-approximation controller for a PWM DAC plus comparator ADC front end.
// Each trial code is held for SETTLE_PERIODS DAC periods before the comparator decides its bit.
module pwm_sar_adc_ctrl #(
  parameter int WIDTH          = 13,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             continuous,
  input  logic             zero,
  input  logic             comparator,
  output logic [WIDTH-1:0] duty_cycle,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WIDTH-1:0] MSB_BIT  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [7:0]       SETTLE_N = 8'(SETTLE_PERIODS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             cmp_meta_q, cmp_sync_q;
  logic             zero_prev_q, zero_prev_d;
  logic [7:0]       settle_q, settle_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_dec;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             period_edge;

  // Rising edge of the period marker, seen only on enabled samples.
  assign period_edge = enable & zero & ~zero_prev_q;
  assign idx_dec     = idx_q - IDX_ONE;

  always_comb begin
    state_d     = state_q;
    zero_prev_d = zero_prev_q;
    settle_d    = settle_q;
    idx_d       = idx_q;
    trial_d     = trial_q;
    duty_d      = duty_q;
    result_d    = result_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    if (enable) begin
      zero_prev_d = zero;
      valid_d     = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start || continuous) begin
            idx_d    = MSB_IDX;
            trial_d  = MSB_BIT;
            settle_d = 8'd0;
            busy_d   = 1'b1;
            state_d  = S_SET;
          end
        end
        S_SET: begin
          duty_d  = trial_q;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (period_edge) begin
            settle_d = settle_q + 8'd1;
            if (settle_q + 8'd1 == SETTLE_N) state_d = S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          // A low comparator means the trial overshot the input: drop this bit.
          trial_d[idx_q] = cmp_sync_q;
          if (idx_q != '0) begin
            idx_d          = idx_dec;
            trial_d[idx_dec] = 1'b1;
            settle_d       = 8'd0;
            state_d        = S_SET;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          result_d = trial_q;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cmp_meta_q  <= 1'b0;
      cmp_sync_q  <= 1'b0;
      zero_prev_q <= 1'b0;
      settle_q    <= 8'd0;
      idx_q       <= '0;
      trial_q     <= '0;
      duty_q      <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmp_meta_q  <= comparator;
      cmp_sync_q  <= cmp_meta_q;
      zero_prev_q <= zero_prev_d;
      settle_q    <= settle_d;
      idx_q       <= idx_d;
      trial_q     <= trial_d;
      duty_q      <= duty_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign duty_cycle = duty_q;
  assign result     = result_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule
